// File: rtl/tx_readout_ctrl.sv
// tx_readout_ctrl: sequences readout of the feature transmit buffer.
// A start request snapshots the buffer word count, drains exactly that many
// words through a 1-cycle-latency read port and emits them as packets of at
// most MAX_BURST beats on a valid/ready stream, with IFG_CYCLES idle cycles
// between packets.
// Optional feature: define TX_READOUT_HDR_EN to prefix every packet with one
// header beat {16'hA55A, packet index, payload length, 16'h0000}.
module tx_readout_ctrl #(
  parameter int DATA_W     = 64,
  parameter int CNT_W      = 13,
  parameter int MAX_BURST  = 256,
  parameter int IFG_CYCLES = 12
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              start,
  output logic              read_start,
  input  logic [CNT_W-1:0]  buffer_data_count,
  output logic              buffer_rd_en,
  input  logic [DATA_W-1:0] buffer_rd_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] MAX_B = CNT_W'(MAX_BURST);
  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES + 1) : 1;

  typedef enum logic [2:0] {IDLE, SNAP, LOAD, SEND, GAP, FIN} stateT;

  stateT             r_state;
  logic [CNT_W-1:0]  r_total;
  logic [CNT_W-1:0]  r_rdLeft;
  logic [GAP_W-1:0]  r_gapCnt;
  logic              r_readStart;
  logic              r_done;
  logic              r_busy;
  logic              r_inflight;
  logic              r_inflightLast;
  logic [DATA_W-1:0] r_bufData [2];
  logic              r_bufLast [2];
  logic [1:0]        r_occ;

  logic              w_pop;
  logic              w_rdEn;
  logic              w_pktEnd;
  logic              w_push;
  logic              w_pushLast;
  logic              w_wrIdx;
  logic              w_hdrPush;
  logic [2:0]        w_level;
  logic [CNT_W-1:0]  w_firstPkt;
  logic [CNT_W-1:0]  w_nextPkt;
  logic [DATA_W-1:0] w_pushData;
  logic [DATA_W-1:0] w_hdrData;

  // r_total holds words not yet allotted to a packet, so the next packet
  // length is simply the smaller of that and the burst limit.
  assign w_firstPkt = (buffer_data_count > MAX_B) ? MAX_B : buffer_data_count;
  assign w_nextPkt  = (r_total > MAX_B) ? MAX_B : r_total;

  assign m_valid = (r_occ != 2'd0);
  assign m_data  = r_bufData[0];
  assign m_last  = r_bufLast[0];
  assign w_pop   = m_valid & m_ready;

  // Words held plus the one in flight must stay below two after this
  // cycle's pop, so a read issued now always has a slot to land in.
  assign w_level      = 3'(r_occ) + 3'(r_inflight) - 3'(w_pop);
  assign w_rdEn       = (r_state == SEND) && (r_rdLeft != '0) && (w_level < 3'd2);
  assign buffer_rd_en = w_rdEn;
  assign w_pktEnd     = (r_state == SEND) && w_pop && m_last;

  assign read_start = r_readStart;
  assign done       = r_done;
  assign busy       = r_busy;

`ifdef TX_READOUT_HDR_EN
  logic [15:0]      r_pktIdx;
  logic             w_enterSend;
  logic [CNT_W-1:0] w_enterLen;
  logic [15:0]      w_hdrIdx;

  // Detect every transition into SEND, which is where a header is due.
  always_comb begin
    w_enterSend = 1'b0;
    w_enterLen  = w_nextPkt;
    if ((r_state == LOAD) && (buffer_data_count != '0)) begin
      w_enterSend = 1'b1;
      w_enterLen  = w_firstPkt;
    end else if ((r_state == GAP) && (r_gapCnt == GAP_W'(1))) begin
      w_enterSend = 1'b1;
    end else if (w_pktEnd && (r_total != '0) && (IFG_CYCLES == 0)) begin
      w_enterSend = 1'b1;
    end
  end

  assign w_hdrIdx  = (r_state == LOAD) ? 16'd0 : r_pktIdx;
  assign w_hdrPush = w_enterSend;
  assign w_hdrData = DATA_W'({16'hA55A, w_hdrIdx, 16'(w_enterLen), 16'h0000});

  // Packet index for the next header; restarts at zero for every drain.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_pktIdx <= 16'd0;
    end else if (w_hdrPush) begin
      r_pktIdx <= w_hdrIdx + 16'd1;
    end
  end
`else
  assign w_hdrPush = 1'b0;
  assign w_hdrData = '0;
`endif

  // Header pushes only happen when nothing is in flight, so the two push
  // sources never collide.
  assign w_push     = r_inflight | w_hdrPush;
  assign w_pushData = r_inflight ? buffer_rd_data : w_hdrData;
  assign w_pushLast = r_inflight & r_inflightLast;
  assign w_wrIdx    = (r_occ == 2'd2) || ((r_occ == 2'd1) && !w_pop);

  // Control FSM: snapshot, packet sizing, inter-packet gap and completion.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state     <= IDLE;
      r_total     <= '0;
      r_rdLeft    <= '0;
      r_gapCnt    <= '0;
      r_readStart <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_readStart <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= SNAP;
            r_readStart <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        SNAP: begin
          r_state <= LOAD;
        end
        LOAD: begin
          if (buffer_data_count == '0) begin
            r_state <= FIN;
            r_done  <= 1'b1;
          end else begin
            r_total  <= buffer_data_count - w_firstPkt;
            r_rdLeft <= w_firstPkt;
            r_state  <= SEND;
          end
        end
        SEND: begin
          if (w_rdEn) begin
            r_rdLeft <= r_rdLeft - 1'b1;
          end
          if (w_pktEnd) begin
            if (r_total != '0) begin
              if (IFG_CYCLES > 0) begin
                r_state  <= GAP;
                r_gapCnt <= GAP_W'(IFG_CYCLES);
              end else begin
                r_rdLeft <= w_nextPkt;
                r_total  <= r_total - w_nextPkt;
              end
            end else begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end
          end
        end
        GAP: begin
          if (r_gapCnt == GAP_W'(1)) begin
            r_rdLeft <= w_nextPkt;
            r_total  <= r_total - w_nextPkt;
            r_state  <= SEND;
          end else begin
            r_gapCnt <= r_gapCnt - 1'b1;
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Track the single outstanding read and whether it closes the packet.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_inflight     <= 1'b0;
      r_inflightLast <= 1'b0;
    end else begin
      r_inflight     <= w_rdEn;
      r_inflightLast <= w_rdEn && (r_rdLeft == CNT_W'(1));
    end
  end

  // Two-entry holding buffer; entry 0 is always the beat on the stream.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_bufData[i] <= '0;
        r_bufLast[i] <= 1'b0;
      end
      r_occ <= 2'd0;
    end else begin
      if (w_pop) begin
        r_bufData[0] <= r_bufData[1];
        r_bufLast[0] <= r_bufLast[1];
      end
      if (w_push) begin
        r_bufData[w_wrIdx] <= w_pushData;
        r_bufLast[w_wrIdx] <= w_pushLast;
      end
      r_occ <= r_occ + 2'(w_push) - 2'(w_pop);
    end
  end

endmodule

// File: tb/tb_tx_readout_ctrl.sv
// tb_tx_readout_ctrl: scoreboard bench for tx_readout_ctrl.
// Stimulus tasks push the expected beats into a queue; a negedge monitor pops
// and compares whenever the DUT hands over a beat. Define TX_READOUT_HDR_EN
// for both files to exercise the header variant.
module tb_tx_readout_ctrl;

  localparam int DATA_W     = 64;
  localparam int CNT_W      = 13;
  localparam int MAX_BURST  = 256;
  localparam int IFG_CYCLES = 12;

  logic              sclk = 1'b0;
  logic              s_rst_n = 1'b0;
  logic              start = 1'b0;
  logic              read_start;
  logic [CNT_W-1:0]  buffer_data_count = '0;
  logic              buffer_rd_en;
  logic [DATA_W-1:0] buffer_rd_data = '0;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_last;
  logic              m_ready = 1'b0;
  logic              busy;
  logic              done;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic        hdr;
  } beatT;

  beatT        expQ[$];
  logic [63:0] mem [0:1023];

  int   errors = 0;
  int   checks = 0;
  int   curN = 0;
  int   rdPtr = 0;
  int   rdIssued = 0;
  int   payloadPops = 0;
  int   lastCount = 0;
  int   doneCount = 0;
  int   readStartCount = 0;
  int   gapIdle = 0;
  int   drainId = 0;
  bit   gapActive = 1'b0;
  bit   prevStall = 1'b0;
  bit   readyRandom = 1'b0;
  logic [63:0] prevData = '0;
  logic        prevLast = 1'b0;
  beatT        popped;

  tx_readout_ctrl #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .MAX_BURST(MAX_BURST), .IFG_CYCLES(IFG_CYCLES)
  ) dut (
    .sclk(sclk),
    .s_rst_n(s_rst_n),
    .start(start),
    .read_start(read_start),
    .buffer_data_count(buffer_data_count),
    .buffer_rd_en(buffer_rd_en),
    .buffer_rd_data(buffer_rd_data),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_last(m_last),
    .m_ready(m_ready),
    .busy(busy),
    .done(done)
  );

  always #5 sclk = ~sclk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Sink ready: held high, or a coin toss per cycle when randomised.
  initial begin
    forever begin
      @(posedge sclk);
      #1;
      m_ready = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Transmit buffer model: read data appears one cycle after the strobe.
  always @(posedge sclk) begin
    if (buffer_rd_en) begin
      checkOutput("rd_within_total", 64'(rdPtr < curN), 64'd1);
      buffer_rd_data <= mem[rdPtr[9:0]];
      rdPtr++;
      rdIssued++;
    end
  end

  // Monitor: pulse counting, stall stability, gap length and beat scoreboard.
  always @(negedge sclk) begin
    if (done) begin
      doneCount++;
      checkOutput("done_with_read_start", 64'(read_start), 64'd0);
    end
    if (read_start) readStartCount++;
    if (busy) checkOutput("held_words", 64'((rdIssued - payloadPops) <= 2), 64'd1);
    if (prevStall) begin
      checkOutput("stall_valid", 64'(m_valid), 64'd1);
      checkOutput("stall_data", m_data, prevData);
      checkOutput("stall_last", 64'(m_last), 64'(prevLast));
    end
    if (gapActive) begin
      if (m_valid) begin
        checkOutput("gap_idle_ok", 64'(gapIdle >= IFG_CYCLES), 64'd1);
        gapActive = 1'b0;
      end else begin
        gapIdle++;
      end
    end
    if (m_valid && m_ready) begin
      checkOutput("beat_expected", 64'(expQ.size() != 0), 64'd1);
      if (expQ.size() != 0) begin
        popped = expQ.pop_front();
        checkOutput("beat_data", m_data, popped.data);
        checkOutput("beat_last", 64'(m_last), 64'(popped.last));
        if (!popped.hdr) payloadPops++;
        if (popped.last) begin
          lastCount++;
          if (expQ.size() != 0) begin
            gapActive = 1'b1;
            gapIdle   = 0;
          end
        end
      end
    end
    prevStall = m_valid && !m_ready;
    prevData  = m_data;
    prevLast  = m_last;
  end

  // Fill the buffer model and queue the expected beats for an n-word drain.
  task automatic prepareDrain(input int n);
    int idx;
    int len;
    int pkt;
    drainId++;
    curN        = n;
    rdPtr       = 0;
    rdIssued    = 0;
    payloadPops = 0;
    for (int i = 0; i < n; i++) mem[i] = {8'hD0, 8'(drainId), 16'h0000, 32'(i)};
    idx = 0;
    pkt = 0;
    while (idx < n) begin
      len = ((n - idx) > MAX_BURST) ? MAX_BURST : (n - idx);
`ifdef TX_READOUT_HDR_EN
      expQ.push_back('{data: {16'hA55A, 16'(pkt), 16'(len), 16'h0000}, last: 1'b0, hdr: 1'b1});
`endif
      for (int j = 0; j < len; j++)
        expQ.push_back('{data: mem[idx + j], last: (j == len - 1), hdr: 1'b0});
      idx += len;
      pkt++;
    end
    buffer_data_count = CNT_W'(n);
  endtask

  // One full drain of n words, then end-of-drain bookkeeping checks.
  task automatic applyStimulus(input int n, input bit rnd, input int expPkts);
    int  doneBase;
    int  rsBase;
    int  lastBase;
    int  cyc;
    bit  seen;
    prepareDrain(n);
    readyRandom = rnd;
    doneBase = doneCount;
    rsBase   = readStartCount;
    lastBase = lastCount;
    @(posedge sclk);
    #1;
    start = 1'b1;
    @(posedge sclk);
    #1;
    start = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (cyc < 4000) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge sclk);
      #1;
      cyc++;
    end
    checkOutput("done_seen", 64'(seen), 64'd1);
    if (n == 0) checkOutput("empty_done_latency", 64'(cyc), 64'd3);
    repeat (3) @(posedge sclk);
    #1;
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    checkOutput("rd_en_count", 64'(rdIssued), 64'(n));
    checkOutput("payload_beats", 64'(payloadPops), 64'(n));
    checkOutput("done_pulses", 64'(doneCount - doneBase), 64'd1);
    checkOutput("read_start_pulses", 64'(readStartCount - rsBase), 64'd1);
    checkOutput("packet_count", 64'(lastCount - lastBase), 64'(expPkts));
    checkOutput("busy_after_drain", 64'(busy), 64'd0);
    readyRandom = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_read_start"}, 64'(read_start), 64'd0);
    checkOutput({tag, "_rd_en"}, 64'(buffer_rd_en), 64'd0);
    checkOutput({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    checkOutput({tag, "_m_last"}, 64'(m_last), 64'd0);
    checkOutput({tag, "_m_data"}, m_data, 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
  endtask

  // Second start mid-SEND must be ignored; reset mid-packet aborts silently.
  task automatic resetMidPacket();
    int doneBase;
    int rsBase;
    int cyc;
    prepareDrain(100);
    readyRandom = 1'b0;
    doneBase = doneCount;
    rsBase   = readStartCount;
    @(posedge sclk);
    #1;
    start = 1'b1;
    @(posedge sclk);
    #1;
    start = 1'b0;
    cyc = 0;
    while ((payloadPops < 20) && (cyc < 2000)) begin
      @(posedge sclk);
      #1;
      cyc++;
    end
    checkOutput("reached_mid_packet", 64'(payloadPops >= 20), 64'd1);
    start = 1'b1;
    @(posedge sclk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge sclk);
    #1;
    checkOutput("second_start_ignored", 64'(readStartCount - rsBase), 64'd1);
    checkOutput("busy_mid_packet", 64'(busy), 64'd1);
    s_rst_n = 1'b0;
    expQ.delete();
    gapActive = 1'b0;
    #1;
    checkAllZero("in_reset");
    @(posedge sclk);
    #1;
    s_rst_n = 1'b1;
    repeat (3) @(posedge sclk);
    #1;
    checkAllZero("after_reset");
    checkOutput("no_done_on_reset", 64'(doneCount - doneBase), 64'd0);
  endtask

  initial begin
    $display("[TB] starting tx_readout_ctrl bench");
    #2;
    checkAllZero("reset");
    repeat (2) @(posedge sclk);
    #1;
    s_rst_n = 1'b1;
    repeat (2) @(posedge sclk);
    #1;
    checkAllZero("idle");
    applyStimulus(0, 1'b0, 0);
    applyStimulus(5, 1'b0, 1);
    applyStimulus(600, 1'b0, 3);
    applyStimulus(40, 1'b1, 1);
    applyStimulus(300, 1'b0, 2);
    resetMidPacket();
    applyStimulus(7, 1'b0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
